// File: rtl/qpsk_mapper.sv
// qpsk_mapper: pairs serial interleaver bits into Gray-coded QPSK I/Q symbols in Q1.15.
// Define QPSK_SKID_EN to add a one-symbol skid buffer with a registered ready_out.
module qpsk_mapper #(
    parameter int          Ncbps = 192,
    parameter int          Ncpc  = 2,
    parameter int          W     = 16,
    parameter logic [W-1:0] AMP  = 16'h5A82
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [W-1:0] i_out,
    output logic [W-1:0] q_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         last_out
);

    localparam int             SYMS     = Ncbps / Ncpc;
    localparam int             CW       = $clog2(SYMS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SYMS - 1);
    localparam logic [W-1:0]   AMP_NEG  = -AMP;

    logic          phase;
    logic          b0;
    logic [CW-1:0] sym_cnt;
    logic          accept;
    logic          load;
    logic [W-1:0]  new_i;
    logic [W-1:0]  new_q;
    logic          new_last;

    assign accept   = valid_in && ready_out;
    assign load     = accept && phase;
    assign new_i    = b0 ? AMP_NEG : AMP;
    assign new_q    = data_in ? AMP_NEG : AMP;
    assign new_last = (sym_cnt == CNT_LAST);

    // Pairing phase, first-bit store and per-block symbol counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase   <= 1'b0;
            b0      <= 1'b0;
            sym_cnt <= '0;
        end else if (accept) begin
            phase <= ~phase;
            if (!phase)
                b0 <= data_in;
            if (phase)
                sym_cnt <= new_last ? '0 : sym_cnt + 1'b1;
        end
    end

`ifdef QPSK_SKID_EN
    logic         skid_v;
    logic [W-1:0] skid_i;
    logic [W-1:0] skid_q;
    logic         skid_l;
    logic         out_v_n;
    logic [W-1:0] out_i_n;
    logic [W-1:0] out_q_n;
    logic         out_l_n;
    logic         sk_v_n;
    logic [W-1:0] sk_i_n;
    logic [W-1:0] sk_q_n;
    logic         sk_l_n;
    logic         phase_n;

    // Drain first (skid moves forward), then place a new symbol in the first free slot.
    always_comb begin
        out_v_n = valid_out;
        out_i_n = i_out;
        out_q_n = q_out;
        out_l_n = last_out;
        sk_v_n  = skid_v;
        sk_i_n  = skid_i;
        sk_q_n  = skid_q;
        sk_l_n  = skid_l;
        phase_n = accept ? ~phase : phase;
        if (valid_out && ready_in) begin
            out_v_n = skid_v;
            out_i_n = skid_i;
            out_q_n = skid_q;
            out_l_n = skid_l;
            sk_v_n  = 1'b0;
        end
        if (load) begin
            if (!out_v_n) begin
                out_v_n = 1'b1;
                out_i_n = new_i;
                out_q_n = new_q;
                out_l_n = new_last;
            end else begin
                sk_v_n = 1'b1;
                sk_i_n = new_i;
                sk_q_n = new_q;
                sk_l_n = new_last;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            skid_v    <= 1'b0;
            skid_i    <= '0;
            skid_q    <= '0;
            skid_l    <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            valid_out <= out_v_n;
            last_out  <= out_l_n;
            i_out     <= out_i_n;
            q_out     <= out_q_n;
            skid_v    <= sk_v_n;
            skid_i    <= sk_i_n;
            skid_q    <= sk_q_n;
            skid_l    <= sk_l_n;
            ready_out <= !(out_v_n && sk_v_n && phase_n);
        end
    end
`else
    // A first bit never needs a slot; a second bit needs the output register free.
    assign ready_out = !phase || !valid_out || ready_in;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
        end else if (load) begin
            valid_out <= 1'b1;
            last_out  <= new_last;
            i_out     <= new_i;
            q_out     <= new_q;
        end else if (ready_in) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed testbench for qpsk_mapper: mapping, latency, block marking, stalls, gaps, reset.
// Expectations adapt when compiled with QPSK_SKID_EN.
module tb_qpsk_mapper;

    localparam logic [15:0] POS = 16'h5A82;
    localparam logic [15:0] NEG = 16'hA57E;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        data_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;
    logic        ready_out;
    logic        valid_out;
    logic        last_out;
    logic [15:0] i_out;
    logic [15:0] q_out;

    int total = 0;
    int bad = 0;

    logic [32:0] sym_q[$];
    logic        bit_q[$];
    logic [191:0] pat;

    qpsk_mapper dut (
        .clk(clk), .resetN(resetN), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .i_out(i_out), .q_out(q_out), .valid_out(valid_out),
        .ready_in(ready_in), .last_out(last_out)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees the values used at the next edge.
    always @(negedge clk) begin
        if (resetN) begin
            if (valid_out && ready_in) sym_q.push_back({last_out, i_out, q_out});
            if (valid_in && ready_out) bit_q.push_back(data_in);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (2) step();
        resetN = 1'b1;
        step();
        sym_q.delete();
        bit_q.delete();
    endtask

    task automatic send_bit(input logic b);
        int t = 0;
        data_in = b;
        valid_in = 1'b1;
        #1;
        while (!ready_out && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        total++;
        if (t >= 200) begin
            bad++;
            $display("FAIL send_bit_timeout: ready_out=%0b required=1", ready_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) step();
        total++;
        if ({valid_out, last_out} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: valid/last=%b required=00", {valid_out, last_out});
        end
        total++;
        if ({i_out, q_out} !== 32'h0) begin
            bad++;
            $display("FAIL reset_iq: i=%h q=%h required 0000/0000", i_out, q_out);
        end
        resetN = 1'b1;
        step();
        total++;
        if (ready_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: ready_out=%b required=1", ready_out);
        end
    endtask

    task automatic test_basic();
        logic        bits[8] = '{0, 1, 0, 0, 1, 0, 1, 1};
        logic [15:0] ei[4] = '{POS, POS, NEG, NEG};
        logic [15:0] eq[4] = '{NEG, POS, POS, NEG};
        ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_bit(bits[k]);
            if (k % 2 == 1) begin
                total++;
                if (valid_out !== 1'b1 || i_out !== ei[k/2] || q_out !== eq[k/2]) begin
                    bad++;
                    $display("FAIL basic_sym%0d: v=%b i=%h q=%h required v=1 i=%h q=%h",
                             k/2, valid_out, i_out, q_out, ei[k/2], eq[k/2]);
                end
            end else if (k > 0) begin
                total++;
                if (valid_out !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_bubble%0d: valid_out=%b required=0", k, valid_out);
                end
            end
        end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_block();
        logic [32:0] e;
        do_reset();
        for (int k = 0; k < 192; k++) send_bit(pat[191-k]);
        send_bit(1'b0);
        send_bit(1'b0);
        valid_in = 1'b0;
        repeat (3) step();
        total++;
        if (sym_q.size() !== 97) begin
            bad++;
            $display("FAIL block_count: symbols=%0d required=97", sym_q.size());
        end
        for (int k = 0; k < 96 && k < sym_q.size(); k++) begin
            e = {(k == 95), pat[191-2*k] ? NEG : POS, pat[190-2*k] ? NEG : POS};
            total++;
            if (sym_q[k] !== e) begin
                bad++;
                $display("FAIL block_sym%0d: got=%h required=%h", k, sym_q[k], e);
            end
        end
        if (sym_q.size() > 96) begin
            total++;
            if (sym_q[96] !== {1'b0, POS, POS}) begin
                bad++;
                $display("FAIL block2_first: got=%h required=%h", sym_q[96], {1'b0, POS, POS});
            end
        end
    endtask

    task automatic test_stall();
        logic        s[8] = '{0, 1, 1, 1, 0, 0, 0, 0};
        logic [32:0] exp_q[$];
        int          idx = 0;
`ifdef QPSK_SKID_EN
        int          exp_acc = 5;
`else
        int          exp_acc = 3;
`endif
        do_reset();
        ready_in = 1'b0;
        valid_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            data_in = s[idx];
            #1;
            if (ready_out) idx++;
            @(posedge clk);
            #1;
        end
        total++;
        if (idx !== exp_acc) begin
            bad++;
            $display("FAIL stall_accepted: bits=%0d required=%0d", idx, exp_acc);
        end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (valid_out !== 1'b1 || i_out !== POS || q_out !== NEG || ready_out !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: v=%b i=%h q=%h rdy=%b required v=1 i=%h q=%h rdy=0",
                         c, valid_out, i_out, q_out, ready_out, POS, NEG);
            end
            step();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
`ifndef QPSK_SKID_EN
        #1;
        total++;
        if (ready_out !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ready: ready_out=%b required=1", ready_out);
        end
`endif
        repeat (4) step();
        send_bit(1'b1);
        valid_in = 1'b0;
        repeat (3) step();
        exp_q.push_back({1'b0, POS, NEG});
        exp_q.push_back({1'b0, NEG, NEG});
`ifdef QPSK_SKID_EN
        exp_q.push_back({1'b0, POS, NEG});
`endif
        total++;
        if (sym_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL stall_count: symbols=%0d required=%0d", sym_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < sym_q.size(); k++) begin
            total++;
            if (sym_q[k] !== exp_q[k]) begin
                bad++;
                $display("FAIL stall_sym%0d: got=%h required=%h", k, sym_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        total++;
        if (valid_out !== 1'b1 || i_out !== NEG || q_out !== POS) begin
            bad++;
            $display("FAIL b2b_first: v=%b i=%h q=%h required v=1 i=%h q=%h", valid_out, i_out, q_out, NEG, POS);
        end
        ready_in = 1'b0;
        send_bit(1'b0);
        total++;
        if (valid_out !== 1'b1 || i_out !== NEG || q_out !== POS) begin
            bad++;
            $display("FAIL b2b_hold: v=%b i=%h q=%h required v=1 i=%h q=%h", valid_out, i_out, q_out, NEG, POS);
        end
        ready_in = 1'b1;
        send_bit(1'b0);
        total++;
        if (valid_out !== 1'b1 || i_out !== POS || q_out !== POS) begin
            bad++;
            $display("FAIL b2b_swap: v=%b i=%h q=%h required v=1 i=%h q=%h", valid_out, i_out, q_out, POS, POS);
        end
        valid_in = 1'b0;
        repeat (2) step();
        total++;
        if (sym_q.size() !== 2 || sym_q[0] !== {1'b0, NEG, POS} || sym_q[1] !== {1'b0, POS, POS}) begin
            bad++;
            $display("FAIL b2b_stream: count=%0d required 2 symbols A57E/5A82 then 5A82/5A82", sym_q.size());
        end
    endtask

    task automatic test_gaps();
        logic        bits[8] = '{0, 1, 0, 0, 1, 0, 1, 1};
        logic [32:0] e[4] = '{{1'b0, POS, NEG}, {1'b0, POS, POS}, {1'b0, NEG, POS}, {1'b0, NEG, NEG}};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send_bit(bits[k]);
            valid_in = 1'b0;
            repeat (3) step();
        end
        total++;
        if (sym_q.size() !== 4) begin
            bad++;
            $display("FAIL gaps_count: symbols=%0d required=4", sym_q.size());
        end
        for (int k = 0; k < 4 && k < sym_q.size(); k++) begin
            total++;
            if (sym_q[k] !== e[k]) begin
                bad++;
                $display("FAIL gaps_sym%0d: got=%h required=%h", k, sym_q[k], e[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        valid_in = 1'b0;
        resetN = 1'b0;
        #1;
        total++;
        if (valid_out !== 1'b0 || last_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: valid=%b last=%b required 0/0", valid_out, last_out);
        end
        step();
        resetN = 1'b1;
        step();
        sym_q.delete();
        send_bit(1'b0);
        send_bit(1'b0);
        total++;
        if (valid_out !== 1'b1 || i_out !== POS || q_out !== POS || last_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset_first: v=%b i=%h q=%h last=%b required v=1 i=%h q=%h last=0",
                     valid_out, i_out, q_out, last_out, POS, POS);
        end
        for (int k = 2; k < 192; k++) send_bit(pat[191-k]);
        valid_in = 1'b0;
        repeat (3) step();
        total++;
        if (sym_q.size() !== 96) begin
            bad++;
            $display("FAIL midreset_count: symbols=%0d required=96", sym_q.size());
        end
        for (int k = 0; k < sym_q.size(); k++) begin
            total++;
            if (sym_q[k][32] !== (k == 95)) begin
                bad++;
                $display("FAIL midreset_last%0d: last=%b required=%b", k, sym_q[k][32], (k == 95));
            end
        end
    endtask

    task automatic test_random();
        int          cyc = 0;
        logic [32:0] e;
        do_reset();
        while (sym_q.size() < 960 && cyc < 30000) begin
            valid_in = (bit_q.size() < 1920) && ($urandom_range(0, 3) != 0);
            data_in  = 1'($urandom_range(0, 1));
            ready_in = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        step();
        total++;
        if (sym_q.size() !== 960 || bit_q.size() !== 1920) begin
            bad++;
            $display("FAIL random_count: symbols=%0d bits=%0d required 960/1920", sym_q.size(), bit_q.size());
        end
        for (int k = 0; k < sym_q.size() && 2*k+1 < bit_q.size(); k++) begin
            e = {(k % 96 == 95), bit_q[2*k] ? NEG : POS, bit_q[2*k+1] ? NEG : POS};
            total++;
            if (sym_q[k] !== e) begin
                bad++;
                $display("FAIL random_sym%0d: got=%h required=%h", k, sym_q[k], e);
            end
        end
    endtask

    initial begin
        pat = 192'h4B047DFA_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0246_BD1E;
        test_reset();
        test_basic();
        test_block();
        test_stall();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
